// File: rtl/function_call_sequencer.sv
// rtl/function_call_sequencer.sv - call/return sequencer driving external function and TOS stacks
// Optional macro FUNC_RETVAL_CAPTURE_EN: load the return value register during RET_DEC.
module function_call_sequencer #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 12,
   parameter int MAX_DEPTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  CALL_REQ,
   input  logic                  RET_REQ,
   input  logic [ADDR_WIDTH-1:0] PC_IN,
   input  logic [ADDR_WIDTH-1:0] TOS_IN,
   input  logic [DATA_WIDTH-1:0] RET_VALUE_IN,
   input  logic [ADDR_WIDTH-1:0] STACK_FUNCTION_OUT,
   input  logic [ADDR_WIDTH-1:0] STACK_TOS_OUT,
   output logic                  CTRL_REG_TOS_FUNCTION,
   output logic                  CTRL_STACK_FUNCTION,
   output logic                  SEL_SOMADOR_SUBTRATOR,
   output logic                  CTRL_REG_DATA_RETURN,
   output logic [ADDR_WIDTH-1:0] STACK_FUNCTION_IN,
   output logic [ADDR_WIDTH-1:0] STACK_TOS_IN,
   output logic [DATA_WIDTH-1:0] REG_DATA_RETURN_IN,
   output logic [ADDR_WIDTH-1:0] PC_RESTORE,
   output logic [ADDR_WIDTH-1:0] TOS_RESTORE,
   output logic                  DONE,
   output logic                  BUSY,
   output logic [ADDR_WIDTH-1:0] DEPTH,
   output logic                  STACK_ERR
);

   typedef enum logic [2:0] {
      IDLE, CALL_WR, CALL_INC, RET_DEC, RET_RD, RET_CAP
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] MAX_D = ADDR_WIDTH'(MAX_DEPTH);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] depth_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] tos_q;
   logic [ADDR_WIDTH-1:0] pc_rest_q;
   logic [ADDR_WIDTH-1:0] tos_rest_q;
   logic                  err_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         depth_q    <= '0;
         pc_q       <= '0;
         tos_q      <= '0;
         pc_rest_q  <= '0;
         tos_rest_q <= '0;
         err_q      <= 1'b0;
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // Conflicting or out-of-range requests leave the FSM idle and only flag the error.
               if (CALL_REQ && RET_REQ) begin
                  err_q <= 1'b1;
               end else if (CALL_REQ) begin
                  if (depth_q == MAX_D) begin
                     err_q <= 1'b1;
                  end else begin
                     pc_q    <= PC_IN;
                     tos_q   <= TOS_IN;
                     state_q <= CALL_WR;
                  end
               end else if (RET_REQ) begin
                  if (depth_q == '0) err_q   <= 1'b1;
                  else               state_q <= RET_DEC;
               end
            end
            CALL_WR:  state_q <= CALL_INC;
            CALL_INC: begin
               depth_q <= depth_q + 1'b1;
               state_q <= IDLE;
            end
            RET_DEC: begin
               depth_q <= depth_q - 1'b1;
               state_q <= RET_RD;
            end
            RET_RD:   state_q <= RET_CAP;
            RET_CAP: begin
               pc_rest_q  <= STACK_FUNCTION_OUT;
               tos_rest_q <= STACK_TOS_OUT;
               state_q    <= IDLE;
            end
            default:  state_q <= IDLE;
         endcase
      end
   end

   assign CTRL_STACK_FUNCTION   = (state_q == CALL_WR);
   assign CTRL_REG_TOS_FUNCTION = (state_q == CALL_INC) || (state_q == RET_DEC);
   assign SEL_SOMADOR_SUBTRATOR = (state_q == RET_DEC);
   assign STACK_FUNCTION_IN     = (state_q == CALL_WR) ? pc_q  : '0;
   assign STACK_TOS_IN          = (state_q == CALL_WR) ? tos_q : '0;
   assign DONE                  = (state_q == CALL_INC) || (state_q == RET_CAP);
   assign BUSY                  = (state_q != IDLE);
   assign DEPTH                 = depth_q;
   assign PC_RESTORE            = pc_rest_q;
   assign TOS_RESTORE           = tos_rest_q;
   assign STACK_ERR             = err_q;

`ifdef FUNC_RETVAL_CAPTURE_EN
   assign CTRL_REG_DATA_RETURN  = (state_q == RET_DEC);
   assign REG_DATA_RETURN_IN    = (state_q == RET_DEC) ? RET_VALUE_IN : '0;
`else
   logic unused_retval;
   assign unused_retval         = ^RET_VALUE_IN;
   assign CTRL_REG_DATA_RETURN  = 1'b0;
   assign REG_DATA_RETURN_IN    = '0;
`endif

endmodule

// File: doc/function_call_sequencer.md
FUNCTION_CALL_SEQUENCER -- requirements
Module: function_call_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of return value.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, width of PC, TOS and function-stack pointer.
REQ-003 SHALL have parameter MAX_DEPTH, default 16, maximum nested calls (1..2**ADDR_WIDTH-1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have these request ports:
- CALL_REQ  in  1  call request.
- RET_REQ  in  1  return request.
- PC_IN  in  ADDR_WIDTH  return address to push.
- TOS_IN  in  ADDR_WIDTH  data-stack TOS to push.
- RET_VALUE_IN  in  DATA_WIDTH  function return value.
- STACK_FUNCTION_OUT  in  ADDR_WIDTH  function-stack read data.
- STACK_TOS_OUT  in  ADDR_WIDTH  TOS-stack read data.
REQ-006 SHALL have these stack-control outputs:
- CTRL_REG_TOS_FUNCTION  out  1  pointer update enable.
- CTRL_STACK_FUNCTION  out  1  stack write enable.
- SEL_SOMADOR_SUBTRATOR  out  1  0 = increment, 1 = decrement.
- CTRL_REG_DATA_RETURN  out  1  return-value load.
- STACK_FUNCTION_IN  out  ADDR_WIDTH  push data.
- STACK_TOS_IN  out  ADDR_WIDTH  push data.
- REG_DATA_RETURN_IN  out  DATA_WIDTH  return value.
REQ-007 SHALL have these status outputs:
- PC_RESTORE  out  ADDR_WIDTH  popped return address.
- TOS_RESTORE  out  ADDR_WIDTH  popped TOS.
- DONE  out  1  operation complete pulse.
- BUSY  out  1  high when not IDLE.
- DEPTH  out  ADDR_WIDTH  current nesting depth.
- STACK_ERR  out  1  rejected-request pulse.

Function
REQ-008 SHALL implement Moore FSM states IDLE, CALL_WR, CALL_INC, RET_DEC, RET_RD, RET_CAP; every control output SHALL be decoded from the registered state only.
REQ-009 SHALL sample requests only in IDLE; requests while BUSY=1 SHALL be ignored and not queued.
REQ-010 In IDLE with CALL_REQ=1, RET_REQ=0, DEPTH<MAX_DEPTH, SHALL latch PC_IN and TOS_IN and go to CALL_WR.
REQ-011 CALL_WR SHALL drive CTRL_STACK_FUNCTION=1 with the latched values on STACK_FUNCTION_IN/STACK_TOS_IN, then go to CALL_INC.
REQ-012 CALL_INC SHALL drive CTRL_REG_TOS_FUNCTION=1 and SEL_SOMADOR_SUBTRATOR=0, increment DEPTH, pulse DONE, and return to IDLE; call latency is 2 cycles from the accept edge.
REQ-013 In IDLE with RET_REQ=1, CALL_REQ=0, DEPTH>0, SHALL go to RET_DEC.
REQ-014 RET_DEC SHALL drive CTRL_REG_TOS_FUNCTION=1 and SEL_SOMADOR_SUBTRATOR=1 and decrement DEPTH.
REQ-015 RET_DEC SHALL then go to RET_RD, a one-cycle memory read wait.
REQ-016 RET_RD SHALL then go to RET_CAP.
REQ-017 RET_CAP SHALL register STACK_FUNCTION_OUT into PC_RESTORE and STACK_TOS_OUT into TOS_RESTORE, pulse DONE, and return to IDLE; PC_RESTORE/TOS_RESTORE SHALL be valid from the cycle after DONE and SHALL hold until the next return.
REQ-018 CALL_REQ at DEPTH==MAX_DEPTH (overflow), RET_REQ at DEPTH==0 (underflow), or CALL_REQ and RET_REQ both high in IDLE SHALL be rejected: no state change, no stack control asserted, STACK_ERR high for one cycle.
REQ-019 DEPTH SHALL never wrap and SHALL always equal the number of completed calls minus completed returns.
REQ-020 SEL_SOMADOR_SUBTRATOR SHALL be 0 in all states except RET_DEC; CTRL_STACK_FUNCTION and CTRL_REG_TOS_FUNCTION SHALL never be high in the same cycle.

Reset
REQ-021 reset low SHALL immediately force IDLE, DEPTH=0, PC_RESTORE=0, TOS_RESTORE=0, every control output 0, DONE=0, BUSY=0, STACK_ERR=0, latched PC/TOS=0.
REQ-022 reset asserted mid-operation SHALL abort the operation with no DONE; the first request SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-023 With FUNC_RETVAL_CAPTURE_EN defined: RET_DEC SHALL drive CTRL_REG_DATA_RETURN=1 and REG_DATA_RETURN_IN=RET_VALUE_IN; both outputs SHALL be 0 in all other states.
REQ-024 Without FUNC_RETVAL_CAPTURE_EN: CTRL_REG_DATA_RETURN and REG_DATA_RETURN_IN SHALL be constant 0, and RET_VALUE_IN SHALL be unused.

Verification
REQ-025 Call: PC_IN=0x123, TOS_IN=0x045, CALL_REQ pulse -> CALL_WR writes 0x123/0x045, CALL_INC increments, DONE 2 cycles after the accept edge, DEPTH=1.
REQ-026 Call then return against a stack model -> PC_RESTORE=0x123, TOS_RESTORE=0x045 after RET_CAP, DEPTH=0, return latency 3 cycles.
REQ-027 16 calls then a 17th -> 17th gives STACK_ERR pulse, DEPTH stays 16; 16 returns pop in LIFO order; an extra return gives STACK_ERR.
REQ-028 CALL_REQ and RET_REQ both high at DEPTH=3 -> STACK_ERR pulse, DEPTH=3, no stack strobes; CALL_REQ high during RET_RD is ignored.
REQ-029 reset low during CALL_WR -> all outputs 0 asynchronously, no DONE, DEPTH=0.
REQ-030 With FUNC_RETVAL_CAPTURE_EN, RET_VALUE_IN=0xA5 on return -> CTRL_REG_DATA_RETURN=1 and REG_DATA_RETURN_IN=0xA5 in RET_DEC only; without the macro both stay 0.
